// File: rtl/logic_unit_responder.sv
// Digit-serial bitwise logic unit (OR/AND/XOR/NOR) behind a valid/ready request
// channel and a valid/ready response channel; processes DIGIT bits per cycle, LSB first.
module logic_unit_responder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             busy
);

  localparam int            NDIG = WIDTH / DIGIT;
  localparam int            CW   = $clog2(NDIG) + 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic [DIGIT-1:0] dig;
  logic [WIDTH-1:0] res_shift;

  function automatic logic [DIGIT-1:0] apply_op(input logic [1:0] op,
                                                input logic [DIGIT-1:0] a,
                                                input logic [DIGIT-1:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Each new digit enters at the top, so after NDIG shifts the word is LSB-aligned.
  assign dig       = apply_op(op_q, a_q[DIGIT-1:0], b_q[DIGIT-1:0]);
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    rsp_y_d    = rsp_y_q;
    rsp_zero_d = rsp_zero_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Only the completed word ever reaches the response outputs.
          rsp_y_d    = res_shift;
          rsp_zero_d = (res_shift == '0);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // NOTE: the operand/result shift registers are plain flops, so they are cleared on reset
  // like everything else; no stale data survives an aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      rsp_y_q     <= '0;
      rsp_zero_q  <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      rsp_y_q     <= rsp_y_d;
      rsp_zero_q  <= rsp_zero_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = busy_q;

endmodule

// File: doc/logic_unit_responder.md
Name: logic_unit_responder

Overview:
- Handshake-driven responder for the ALU's bitwise logic path.
- The ALU controller (initiator) issues a request carrying an opcode and two operands. This block computes the result digit-serially, LSB first, and returns it on a response channel with backpressure.
- Trades the area of a full-width parallel gate array for WIDTH/DIGIT cycles of latency. It is the slave end of the controller's logic-op request interface.

Parameters:
- WIDTH, 32: operand and result width in bits.
- DIGIT, 4: bits processed per cycle. WIDTH must be an integer multiple of DIGIT, legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  2  opcode: 00 OR, 01 AND, 10 XOR, 11 NOR.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  initiator accepts the result.
- rsp_y  output  WIDTH  result.
- rsp_zero  output  1  high when rsp_y is all zeros.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of state:
  - state to IDLE; digit counter to 0; operand and result registers to 0.
  - req_ready=0 while rst_n is low, and req_ready=1 from the first clock after release.
  - rsp_valid=0, rsp_y=0, rsp_zero=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid&&req_ready: capture req_op, req_a, req_b into internal registers, clear the counter, go to RUN.
  - req_a, req_b and req_op are sampled only at the accept edge; later changes are ignored.
- RUN:
  - req_ready=0.
  - Each cycle, apply the op to the low DIGIT bits of the A and B shift registers.
  - Shift A and B right by DIGIT.
  - Shift the DIGIT-bit result into the top of the result register, also shifting right.
  - Increment the counter.
  - After WIDTH/DIGIT cycles the result register holds the complete LSB-aligned result; go to DONE.
- Latency: accept at edge N gives rsp_valid high immediately after edge N+WIDTH/DIGIT. Example: WIDTH=32, DIGIT=4 gives 8 cycles.
- DONE:
  - rsp_valid=1, rsp_y=result, rsp_zero=(result==0).
  - All response outputs are held stable while rsp_ready=0, indefinitely.
  - On an edge with rsp_valid&&rsp_ready: go to IDLE; rsp_valid=0 next cycle. rsp_y keeps its last value; rsp_zero keeps its last value.
- Back-to-back operation:
  - req_ready is low in DONE, so no request is accepted on the response-handshake edge.
  - The minimum request-to-request spacing is WIDTH/DIGIT+2 cycles when rsp_ready is held high.
- Output register rules: rsp_y and rsp_zero update only on the RUN→DONE transition. Intermediate partial results are never visible on rsp_y.
- rsp_valid is never asserted combinationally from rsp_ready. req_ready does not depend on req_valid.
- Degenerate DIGIT values:
  - DIGIT==WIDTH: single RUN cycle.
  - DIGIT==1: WIDTH RUN cycles.
- Counter width: clog2(WIDTH/DIGIT)+1. The counter never wraps within an operation.
- Reset mid-operation (RUN or DONE): the operation is discarded and no response is produced. The next request after release behaves as from power-up.
- X on req_* while req_valid=0 must not propagate to any output.

Test Plan:
- OR: req_op=00, A=0xF0F0_0000, B=0x0000_0F0F accepted at edge N → rsp_valid rises after edge N+8, rsp_y=0xF0F0_0F0F, rsp_zero=0.
- AND zero flag: A=0xFFFF_0000, B=0x0000_FFFF, op=01 → rsp_y=0x0000_0000, rsp_zero=1. Then XOR with A=0xAAAA_5555, B=0xFFFF_FFFF → rsp_y=0x5555_AAAA, rsp_zero=0.
- Backpressure:
  - Stimulus: NOR, A=0, B=0; hold rsp_ready=0 for 5 cycles after rsp_valid; drive req_valid=1 with changing operands throughout.
  - Required: rsp_y=0xFFFF_FFFF is stable; req_ready stays 0; no new accept.
  - After rsp_ready=1 for one edge: rsp_valid falls, and the next request is accepted one cycle later.
- Operand isolation: change req_a/req_b every cycle during RUN → result reflects the operands captured at the accept edge only.
- Reset mid-run: assert rst_n=0 at the 3rd RUN cycle → all outputs 0 immediately (asynchronously). After release, OR 0x1 | 0x2 returns 0x3 with normal latency and no stale response.
- Parameter sweep:
  - DIGIT=32: latency 1, OR 0x8000_0001 | 0x0 returns 0x8000_0001.
  - DIGIT=1: latency 32, same result.
  - Random ops/operands (≥1000) checked against a reference model.
